// File: rtl/lane_interleaver_4to1_if.sv
// Lane-side and stream-side signals of the 4:1 lane interleaver.
// The master drives the four lane words; the slave (the interleaver) drives the status flags and the serial stream.
interface lane_interleaver_4to1_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W:0] data_in0;
  logic [DATA_W:0] data_in1;
  logic [DATA_W:0] data_in2;
  logic [DATA_W:0] data_in3;
  logic [3:0]      full;
  logic [3:0]      overflow;
  logic [DATA_W:0] out_word;
  logic [1:0]      out_lane;

  modport master (
    output data_in0, data_in1, data_in2, data_in3,
    input  full, overflow, out_word, out_lane
  );

  modport slave (
    input  data_in0, data_in1, data_in2, data_in3,
    output full, overflow, out_word, out_lane
  );
endinterface

// File: rtl/lane_interleaver_4to1.sv
// Four buffered lanes interleaved into one slot-ordered stream (slots 0,1,2,3 round-robin, one word per clk4f edge).
// Latency: a pushed word can leave one edge later at the earliest, at most 4 edges when its FIFO was empty.
// Backpressure: none; a push into a full lane without a same-edge pop is dropped and sets a sticky overflow flag.
// Option IDLE_COMMA_EN: empty slots emit the comma idle word 9'h0BC instead of 9'h000.

module lane_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk4f,
  input  logic              reset,
  input  logic              push_vld,
  input  logic [DATA_W-1:0] push_dat,
  input  logic              pop,
  output logic [DATA_W-1:0] head_dat,
  output logic              empty,
  output logic              full,
  output logic              drop
);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              pop_ok;
  logic              push_ok;

  assign empty    = (count == '0);
  assign full     = (count == CNT_FULL);
  assign head_dat = mem[rd_ptr];
  assign pop_ok   = pop && !empty;
  // A full lane still accepts a push when the same edge frees its head entry.
  assign push_ok  = push_vld && (!full || pop_ok);
  assign drop     = push_vld && full && !pop_ok;

  always_ff @(posedge clk4f) begin
    if (push_ok && !reset) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk4f) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push_ok && !pop_ok) begin
        count <= count + CNT_ONE;
      end else if (!push_ok && pop_ok) begin
        count <= count - CNT_ONE;
      end
    end
  end
endmodule

module lane_interleaver_4to1 #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic                  clk4f,
  input  logic                  reset,
  lane_interleaver_4to1_if.slave lanes
);
`ifdef IDLE_COMMA_EN
  localparam logic [DATA_W:0] IDLE_WORD = {1'b0, DATA_W'(8'hBC)};
`else
  localparam logic [DATA_W:0] IDLE_WORD = '0;
`endif

  logic [DATA_W:0]   din  [4];
  logic [DATA_W-1:0] head [4];
  logic [3:0]        empty;
  logic [3:0]        full;
  logic [3:0]        drop;
  logic [3:0]        pop;
  logic [1:0]        slot;
  logic [DATA_W:0]   out_word_q;
  logic [1:0]        out_lane_q;
  logic [3:0]        overflow_q;

  assign din[0] = lanes.data_in0;
  assign din[1] = lanes.data_in1;
  assign din[2] = lanes.data_in2;
  assign din[3] = lanes.data_in3;

  for (genvar k = 0; k < 4; k++) begin : g_lane
    // Only the lane owning the current slot is offered a pop; its FIFO ignores it when empty.
    assign pop[k] = (slot == 2'(k));

    lane_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_fifo (
      .clk4f    (clk4f),
      .reset    (reset),
      .push_vld (din[k][DATA_W]),
      .push_dat (din[k][DATA_W-1:0]),
      .pop      (pop[k]),
      .head_dat (head[k]),
      .empty    (empty[k]),
      .full     (full[k]),
      .drop     (drop[k])
    );
  end

  assign lanes.full     = full;
  assign lanes.overflow = overflow_q;
  assign lanes.out_word = out_word_q;
  assign lanes.out_lane = out_lane_q;

  always_ff @(posedge clk4f) begin
    if (reset) begin
      slot       <= '0;
      out_word_q <= '0;
      out_lane_q <= '0;
      overflow_q <= '0;
    end else begin
      slot       <= slot + 2'd1;
      out_lane_q <= slot;
      // The stored valid bit is never used; popped data is always marked valid.
      out_word_q <= empty[slot] ? IDLE_WORD : {1'b1, head[slot]};
      overflow_q <= overflow_q | drop;
    end
  end
endmodule

// File: tb/tb_lane_interleaver_4to1.sv
// Bench for lane_interleaver_4to1: directed scenarios plus random traffic against a queue-based lane model.
module tb_lane_interleaver_4to1;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
`ifdef IDLE_COMMA_EN
  localparam logic [8:0] IDLE = 9'h0BC;
`else
  localparam logic [8:0] IDLE = 9'h000;
`endif

  logic clk4f = 1'b0;
  logic reset = 1'b1;

  lane_interleaver_4to1_if #(.DATA_W(DATA_W)) bus ();

  lane_interleaver_4to1 #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (2)
  ) dut (
    .clk4f (clk4f),
    .reset (reset),
    .lanes (bus)
  );

  always #5 clk4f = ~clk4f;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one queue per lane, a slot number and the last emitted word.
  logic [7:0] q [4][$];
  int         m_slot = 0;
  logic [8:0] m_word = '0;
  logic [1:0] m_lane = '0;
  logic [3:0] m_ovf  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic [8:0] d0, d1, d2, d3, input logic rst);
    logic [8:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    if (rst) begin
      for (int k = 0; k < 4; k++) q[k].delete();
      m_slot = 0;
      m_word = '0;
      m_lane = '0;
      m_ovf  = '0;
    end else begin
      m_lane = 2'(m_slot);
      if (q[m_slot].size() > 0) m_word = {1'b1, q[m_slot].pop_front()};
      else                      m_word = IDLE;
      for (int k = 0; k < 4; k++) begin
        if (d[k][8]) begin
          if (q[k].size() < DEPTH) q[k].push_back(d[k][7:0]);
          else                     m_ovf[k] = 1'b1;
        end
      end
      m_slot = (m_slot + 1) % 4;
    end
  endtask

  task automatic cycle(input logic [8:0] d0, d1, d2, d3, input logic rst, output logic [8:0] ow);
    logic [3:0] exp_full;
    bus.data_in0 = d0;
    bus.data_in1 = d1;
    bus.data_in2 = d2;
    bus.data_in3 = d3;
    reset        = rst;
    @(posedge clk4f);
    model_step(d0, d1, d2, d3, rst);
    #1;
    for (int k = 0; k < 4; k++) exp_full[k] = (q[k].size() == DEPTH);
    check("out_word", 32'(bus.out_word), 32'(m_word));
    check("out_lane", 32'(bus.out_lane), 32'(m_lane));
    check("full",     32'(bus.full),     32'(exp_full));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
    ow = bus.out_word;
  endtask

  task automatic idle(input int n);
    logic [8:0] ow;
    for (int i = 0; i < n; i++) cycle('0, '0, '0, '0, 1'b0, ow);
  endtask

  task automatic align_to(input int s);
    for (int i = 0; i < 4 && m_slot != s; i++) idle(1);
  endtask

  initial begin
    logic [8:0] ow;
    logic [8:0] seen [4];
    logic [7:0] last;
    int         hits;
    int         older;
    logic       found;

    // Reset hold with pushes presented on every lane.
    for (int i = 0; i < 3; i++) cycle(9'h1AA, 9'h1AA, 9'h1AA, 9'h1AA, 1'b1, ow);
    check("rst_word", 32'(bus.out_word), 32'h000);
    check("rst_lane", 32'(bus.out_lane), 32'h0);
    check("rst_full", 32'(bus.full), 32'h0);
    check("rst_ovf",  32'(bus.overflow), 32'h0);
    cycle('0, '0, '0, '0, 1'b0, ow);
    check("post_rst_lane", 32'(bus.out_lane), 32'h0);
    check("post_rst_word", 32'(ow), 32'(IDLE));

    // One word per lane, pushed so the next edge serves slot 0.
    align_to(3);
    cycle(9'h10C, 9'h10F, 9'h111, 9'h117, 1'b0, ow);
    for (int i = 0; i < 4; i++) cycle('0, '0, '0, '0, 1'b0, seen[i]);
    check("single_l0", 32'(seen[0]), 32'h10C);
    check("single_l1", 32'(seen[1]), 32'h10F);
    check("single_l2", 32'(seen[2]), 32'h111);
    check("single_l3", 32'(seen[3]), 32'h117);
    for (int i = 0; i < 4; i++) begin
      cycle('0, '0, '0, '0, 1'b0, ow);
      check("single_idle", 32'(ow), 32'(IDLE));
    end

    // Only lane 2 carries data.
    cycle('0, '0, 9'h13F, '0, 1'b0, ow);
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      cycle('0, '0, '0, '0, 1'b0, ow);
      if (ow == 9'h13F) begin
        hits++;
        check("lane2_slot", 32'(bus.out_lane), 32'h2);
      end else begin
        check("lane2_idle", 32'(ow), 32'(IDLE));
      end
    end
    check("lane2_once", 32'(hits), 32'h1);

    // Fill lane 1 past capacity, then drain it.
    for (int i = 1; i <= 8; i++) cycle('0, {1'b1, 8'(i)}, '0, '0, 1'b0, ow);
    check("fill_ovf1", 32'(bus.overflow[1]), 32'h1);
    last = 8'h00;
    for (int i = 0; i < 24; i++) begin
      cycle('0, '0, '0, '0, 1'b0, ow);
      if (bus.out_lane == 2'd1 && ow[8]) begin
        check("fill_increasing", 32'(ow[7:0] > last), 32'h1);
        last = ow[7:0];
      end
    end
    check("drain_empty_full1", 32'(bus.full[1]), 32'h0);
    check("ovf1_sticky", 32'(bus.overflow[1]), 32'h1);

    // Lane 3 full, push on the edge that also pops it.
    for (int i = 0; i < 40 && !(q[3].size() == DEPTH && m_slot == 3); i++) begin
      if (q[3].size() < DEPTH) cycle('0, '0, '0, {1'b1, 8'(8'h30 + i)}, 1'b0, ow);
      else                     cycle('0, '0, '0, '0, 1'b0, ow);
    end
    check("l3_prefull", 32'(q[3].size() == DEPTH && m_slot == 3), 32'h1);
    cycle('0, '0, '0, 9'h177, 1'b0, ow);
    check("l3_full_kept", 32'(bus.full[3]), 32'h1);
    check("l3_no_ovf", 32'(bus.overflow[3]), 32'h0);
    older = 0;
    found = 1'b0;
    for (int i = 0; i < 24 && !found; i++) begin
      cycle('0, '0, '0, '0, 1'b0, ow);
      if (bus.out_lane == 2'd3 && ow[8]) begin
        if (ow == 9'h177) found = 1'b1;
        else              older++;
      end
    end
    check("l3_177_seen", 32'(found), 32'h1);
    check("l3_older_first", 32'(older), 32'h3);

    // Reset with data buffered in every lane.
    cycle(9'h121, 9'h122, 9'h123, 9'h124, 1'b0, ow);
    cycle(9'h131, 9'h132, 9'h133, 9'h134, 1'b0, ow);
    cycle('0, '0, '0, '0, 1'b1, ow);
    for (int i = 0; i < 8; i++) begin
      cycle('0, '0, '0, '0, 1'b0, ow);
      check("midrst_idle", 32'(ow), 32'(IDLE));
      check("midrst_lane", 32'(bus.out_lane), 32'(i % 4));
    end

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      logic [8:0] d [4];
      for (int k = 0; k < 4; k++) begin
        d[k] = {($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0, 8'($urandom)};
      end
      cycle(d[0], d[1], d[2], d[3], ($urandom_range(0, 99) == 0), ow);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit %0t", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/lane_interleaver_4to1.md
Name: lane_interleaver_4to1

Overview:
- Upstream feeder of the lane demux stage.
- Accepts four 9-bit lane words: bit 8 = valid, bits 7:0 = payload.
- Buffers each lane in its own small FIFO.
- Emits one interleaved 9-bit word per clk4f cycle, visiting slots 0,1,2,3 round-robin. This is the serial stream the demux consumes.
- Empty slots emit an idle word with valid=0, so lane position is always implied by slot order.

Parameters:
- DATA_W, 8, payload width; word width is DATA_W+1.
- DEPTH, 4, entries per lane FIFO; must be a power of two and at least 2.
- ADDR_W, 2, log2(DEPTH).

Ports:
- clk4f  input  1  single clock, one output word per rising edge.
- reset  input  1  synchronous, active-high; sampled on the clk4f rising edge.
- data_in0  input  9  lane 0 word; pushed when bit 8 = 1.
- data_in1  input  9  lane 1 word; same rule.
- data_in2  input  9  lane 2 word; same rule.
- data_in3  input  9  lane 3 word; same rule.
- full  output  4  full[k]=1 when lane k FIFO holds DEPTH entries.
- overflow  output  4  sticky flag per lane; a push was dropped.
- out_word  output  9  interleaved word; bit 8 = valid.
- out_lane  output  2  slot index of the word currently on out_word.

Behaviour:
- Reset: synchronous; all of the following take effect on the rising edge where reset=1.
  - All FIFO counts and pointers go to 0; contents are flushed.
  - Slot counter goes to 0.
  - out_word=9'h000, out_lane=0, full=4'h0, overflow=4'h0.
  - Pushes presented in a reset cycle are ignored.
  - Reset mid-stream drops all buffered words. The first post-reset edge outputs slot 0.
- Slot counter s:
  - 2-bit register; increments every non-reset edge; wraps 3->0 unconditionally.
- Output (registered):
  - Each edge: out_lane <= s.
  - If FIFO[s] is non-empty: out_word <= {1'b1, head payload}; FIFO[s] pops.
  - Else: out_word <= idle word, 9'h000.
  - Output valid bit is always forced to 1 for popped data; the stored valid bit is not used.
- Push:
  - Lane k pushes on an edge where data_in_k[8]=1 and reset=0.
  - Payload data_in_k[7:0] is written at the write pointer.
- Latency:
  - A word pushed at edge n can pop no earlier than edge n+1.
  - It appears on out_word at the first edge m>n with s(m)=k and all older lane-k words already popped.
  - Worst case with an empty FIFO: 4 cycles.
- Full / simultaneous push and pop, per lane:
  - Full is based on the registered count; full[k] = (count==DEPTH).
  - Push while full, with a pop on the same edge: accepted; count unchanged; full stays 1.
  - Push while full, no pop: word dropped; overflow[k] <= 1. overflow clears only on reset.
  - Push and pop on the same edge when not full: count unchanged.
- Empty: pop is suppressed and count never underflows.
- Pointers wrap modulo DEPTH.
- Lanes are independent; no cross-lane ordering is guaranteed beyond slot order.

Optional Feature:
- Macro: IDLE_COMMA_EN.
- Defined:
  - Empty-slot output is 9'h0BC (valid=0, comma payload 8'hBC) instead of 9'h000.
  - Reset value of out_word is still 9'h000.
  - Downstream can use the comma for lane-alignment checks.
- Undefined: idle word is 9'h000 everywhere.

Test Plan:
- Reset hold:
  - Stimulus: reset=1 for 3 edges while all lanes present 9'h1AA.
  - Response: out_word=9'h000, out_lane=0, full=0, overflow=0. The first post-reset edge shows out_lane=0, out_word=9'h000.
- Single word per lane:
  - Stimulus: one edge after reset, push 9'h10C, 9'h10F, 9'h111, 9'h117 on lanes 0..3 in the same cycle.
  - Response: over the next 4 slot edges, out_word = 9'h10C (lane 0), 9'h10F (1), 9'h111 (2), 9'h117 (3); then 9'h000 idle words.
- Idle slots:
  - Stimulus: push only lane 2 with 9'h13F.
  - Response: slots 0, 1, 3 show 9'h000; slot 2 shows 9'h13F once.
  - With IDLE_COMMA_EN defined, slots 0, 1, 3 show 9'h0BC.
- Fill and overflow:
  - Stimulus: push lane 1 every cycle for 8 cycles (payloads 8'h01..8'h08).
  - Response: full[1] rises once 4 entries are held. Pushes that are neither accepted nor matched by a pop set overflow[1]=1.
  - Popped sequence is strictly increasing with no duplicates; overflow stays 1 after the lane drains.
- Full with same-cycle pop:
  - Stimulus: lane 3 full; push 9'h177 on the edge where s=3.
  - Response: word accepted, count stays 4, overflow[3] stays 0; 8'h77 emerges after the three older entries.
- Reset mid-stream:
  - Stimulus: lanes 0..3 each hold 2 entries; assert reset for 1 edge.
  - Response: all buffered data lost. The following 8 edges output only idle words, with out_lane sequencing 0,1,2,3,0,…
